alu_mw_sequencer: RTL
=====================

# alu_mw_sequencer

Multi-word arithmetic sequencer: the command-side initiator for the 16-bit function unit (`ALU`). It accepts an extended-precision ADD/SUB/INC/DEC command and streams operand word pairs in, LSW first. For each word it drives the ALU's select, operand and carry-in inputs, chaining carry/borrow between words, and streams the result words out. Final V/C/N/Z status is registered when the last word leaves.

## Interface
Parameters:
- `WIDTH`, 16: word width; must match the attached ALU.
- `MAX_WORDS`, 8: maximum words per command; `CW = $clog2(MAX_WORDS)+1`.

Ports:
- `CLK` in 1: single clock, rising edge.
- `RST_N` in 1: reset, asynchronous, active-low.
- `CMD_VALID` in 1; `CMD_READY` out 1: command handshake.
- `CMD_OP` in 2: operation, 00 ADD, 01 SUB, 10 INC, 11 DEC.
- `CMD_WORDS` in CW: word count.
- `OPD_VALID` in 1; `OPD_READY` out 1: operand handshake.
- `OPD_A`, `OPD_B` in WIDTH: operand word pair. `OPD_B` is ignored for INC and DEC.
- `RES_VALID` out 1; `RES_READY` in 1: result handshake.
- `RES_G` out WIDTH: result word.
- `RES_LAST` out 1: marks the final result word.
- `ALU_S` out 3; `ALU_CIN` out 1; `ALU_A`, `ALU_B` out WIDTH: registered ALU drive.
- `ALU_G` in WIDTH; `ALU_V`, `ALU_C`, `ALU_N`, `ALU_Z` in 1: combinational ALU response.
- `FLAG_V`, `FLAG_C`, `FLAG_N`, `FLAG_Z` out 1: status of the last completed command.
- `DONE` out 1: one-cycle pulse when the flags update.
- `ERR` out 1: one-cycle pulse on a rejected command (see Configuration).

## Operation
- FSM states: IDLE, LOAD, EXEC, EMIT, DONE.
- Op mapping, as {`ALU_S`, first-word CIN}: ADD {001,0}, SUB {010,1}, INC {000,1}, DEC {011,0}.
- IDLE: `CMD_READY`=1. On handshake, latch op, word count and word index 0, preset chain carry to the first-word CIN, preset z_acc=1, then go to LOAD.
- LOAD: `OPD_READY`=1. On handshake, register `ALU_A`=`OPD_A`, `ALU_B`=`OPD_B` (0 for INC/DEC), `ALU_S`, and `ALU_CIN`=chain carry, then go to EXEC.
- EXEC: one cycle.
  - Capture `ALU_G` into `RES_G`.
  - Update chain carry: `ALU_C` for ADD, SUB and INC; ~`ALU_C` for DEC.
  - Update z_acc &= `ALU_Z`; capture v_last=`ALU_V` and n_last=`ALU_N`.
  - Go to EMIT.
- EMIT: `RES_VALID`=1; `RES_LAST`=1 when word index = count−1.
  - On handshake: if last, load FLAG_V=v_last, FLAG_N=n_last, FLAG_Z=z_acc, FLAG_C=chain carry, then go to DONE.
  - Otherwise increment the word index and go to LOAD.
- DONE: `DONE`=1 for one cycle, then go to IDLE.
- FLAG_C is the normalized carry: 1 means carry-out for ADD/INC and no-borrow for SUB/DEC.
- The ALU's transfer encodings (CIN selects TranA/IncA or TranA2/DecA) carry INC/DEC through the upper words. No op remapping per word.
- Flags hold their values between commands.

## Timing
- Reset values:
  - state IDLE, so `CMD_READY`=1.
  - `OPD_READY`, `RES_VALID`, `RES_LAST`, `DONE`, `ERR` = 0.
  - `ALU_S`=000, `ALU_CIN`=0, `ALU_A`=`ALU_B`=0, `RES_G`=0.
  - All FLAG_* = 0.
- Command accepted at cycle t0 → `OPD_READY` high at t0+1.
- Operand accepted at cycle t → `RES_VALID` high at t+2.
- Throughput: 3 cycles per word with no stalls.
- `RES_G`/`RES_LAST` hold stable while `RES_VALID`=1 and `RES_READY`=0. No operand is accepted during this stall.
- Flags update, and `DONE` asserts, in the cycle after the last `RES` handshake. `CMD_READY` re-asserts one cycle later.
- `RST_N` low mid-command aborts immediately. No partial flag update.

## Configuration
- `ALU_SEQ_LEN_CHECK_EN` defined:
  - `CMD_WORDS`=0 or >`MAX_WORDS`: the command is accepted and no operands are consumed.
  - `ERR` pulses in the cycle after acceptance, flags stay unchanged, `DONE` does not pulse, and the FSM returns to IDLE.
- Undefined:
  - `CMD_WORDS`=0 is treated as 1; values above `MAX_WORDS` are clamped to `MAX_WORDS`.
  - `ERR` is tied to 0.

## Test plan
- ADD, 2 words, A=0x0001_FFFF, B=0x0000_0001 → `RES_G` 0x0000 then 0x0002 (`RES_LAST` on the second); V=0, C=0, N=0, Z=0; `DONE` pulses once.
- SUB, 2 words, A=0x0000_0000, B=0x0000_0001 → 0xFFFF, 0xFFFF; C=0 (borrow), N=1, V=0, Z=0.
- INC, 2 words, A=0x7FFF_FFFF → 0x0000, 0x8000; V=1, N=1, C=0, Z=0.
- DEC, 2 words, A=0x0001_0000 → 0xFFFF, 0x0000; C=1, N=0, Z=0. Then DEC, 1 word, A=0x0001 → 0x0000; Z=1, C=1.
- ADD, 1 word, 0x1234+0x4321 with `RES_READY` low for 5 cycles → `RES_G`=0x5555 held stable and `OPD_READY`=0 throughout; then `RST_N` pulsed during a later EMIT → all reset values, and the next command completes normally.
- With `ALU_SEQ_LEN_CHECK_EN`: `CMD_WORDS`=0 → `ERR` pulse, `OPD_READY` never asserts, flags unchanged. Without it: treated as a 1-word command.

Source files
------------

// File: rtl/alu_mw_sequencer.sv
// alu_mw_sequencer
//   Command-side initiator for a 16-bit function unit. It accepts an
//   extended-precision ADD/SUB/INC/DEC command and streams operand word pairs
//   in, least significant word first. Each word goes through three states:
//   LOAD (take operands and drive the ALU), EXEC (capture the ALU response),
//   EMIT (hand the result word out). Carry/borrow is chained between words.
//   Final V/C/N/Z flags are registered when the last result word leaves.
//
// Ports
//   CLK, RST_N              clock (rising edge), async active-low reset
//   CMD_VALID/CMD_READY     command handshake; CMD_OP, CMD_WORDS
//   OPD_VALID/OPD_READY     operand handshake; OPD_A, OPD_B (B unused for INC/DEC)
//   RES_VALID/RES_READY     result handshake; RES_G, RES_LAST
//   ALU_S/ALU_CIN/ALU_A/B   registered ALU drive
//   ALU_G/V/C/N/Z           combinational ALU response
//   FLAG_V/C/N/Z            status of the last completed command
//   DONE                    one-cycle pulse when the flags update
//   ERR                     one-cycle pulse on a rejected command
//
// Configuration
//   ALU_SEQ_LEN_CHECK_EN    when defined, CMD_WORDS of 0 or above MAX_WORDS is
//                           rejected with an ERR pulse. When undefined, 0 is
//                           treated as 1, larger counts are clamped and ERR
//                           is tied low.

module alu_mw_sequencer #(
    parameter int  WIDTH     = 16,
    parameter int  MAX_WORDS = 8,
    localparam int CW        = $clog2(MAX_WORDS) + 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [1:0]       CMD_OP,
    input  logic [CW-1:0]    CMD_WORDS,
    input  logic             OPD_VALID,
    output logic             OPD_READY,
    input  logic [WIDTH-1:0] OPD_A,
    input  logic [WIDTH-1:0] OPD_B,
    output logic             RES_VALID,
    input  logic             RES_READY,
    output logic [WIDTH-1:0] RES_G,
    output logic             RES_LAST,
    output logic [2:0]       ALU_S,
    output logic             ALU_CIN,
    output logic [WIDTH-1:0] ALU_A,
    output logic [WIDTH-1:0] ALU_B,
    input  logic [WIDTH-1:0] ALU_G,
    input  logic             ALU_V,
    input  logic             ALU_C,
    input  logic             ALU_N,
    input  logic             ALU_Z,
    output logic             FLAG_V,
    output logic             FLAG_C,
    output logic             FLAG_N,
    output logic             FLAG_Z,
    output logic             DONE,
    output logic             ERR
);

    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_EXEC, ST_EMIT, ST_DONE} state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_INC = 2'b10;
    localparam logic [1:0] OP_DEC = 2'b11;

    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     idx_q, idx_d;
    logic              carry_q, carry_d;
    logic              z_acc_q, z_acc_d;
    logic              v_last_q, v_last_d;
    logic              n_last_q, n_last_d;
    logic [2:0]        alu_s_q, alu_s_d;
    logic              alu_cin_q, alu_cin_d;
    logic [WIDTH-1:0]  alu_a_q, alu_a_d;
    logic [WIDTH-1:0]  alu_b_q, alu_b_d;
    logic [WIDTH-1:0]  res_g_q, res_g_d;
    logic              flag_v_q, flag_v_d;
    logic              flag_c_q, flag_c_d;
    logic              flag_n_q, flag_n_d;
    logic              flag_z_q, flag_z_d;
    logic              done_q, done_d;
`ifdef ALU_SEQ_LEN_CHECK_EN
    logic              err_q, err_d;
`endif

    logic              last_word;

    assign last_word = (idx_q == (cnt_q - CW'(1)));

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        z_acc_d   = z_acc_q;
        v_last_d  = v_last_q;
        n_last_d  = n_last_q;
        alu_s_d   = alu_s_q;
        alu_cin_d = alu_cin_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        res_g_d   = res_g_q;
        flag_v_d  = flag_v_q;
        flag_c_d  = flag_c_q;
        flag_n_d  = flag_n_q;
        flag_z_d  = flag_z_q;
        done_d    = 1'b0;
`ifdef ALU_SEQ_LEN_CHECK_EN
        err_d     = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (CMD_VALID) begin
                    op_d    = CMD_OP;
                    idx_d   = '0;
                    z_acc_d = 1'b1;
                    // First-word carry-in: SUB needs +1 for two's complement,
                    // INC needs +1 to select IncA; ADD and DEC start at 0.
                    carry_d = (CMD_OP == OP_SUB) || (CMD_OP == OP_INC);
`ifdef ALU_SEQ_LEN_CHECK_EN
                    if ((CMD_WORDS == '0) || (CMD_WORDS > CW'(MAX_WORDS))) begin
                        // Rejected: no operands consumed, flags untouched.
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d   = CMD_WORDS;
                        state_d = ST_LOAD;
                    end
`else
                    if (CMD_WORDS == '0) begin
                        cnt_d = CW'(1);
                    end else if (CMD_WORDS > CW'(MAX_WORDS)) begin
                        cnt_d = CW'(MAX_WORDS);
                    end else begin
                        cnt_d = CMD_WORDS;
                    end
                    state_d = ST_LOAD;
`endif
                end
            end

            ST_LOAD: begin
                if (OPD_VALID) begin
                    alu_a_d   = OPD_A;
                    alu_b_d   = op_q[1] ? '0 : OPD_B;
                    alu_cin_d = carry_q;
                    case (op_q)
                        OP_ADD:  alu_s_d = 3'b001;
                        OP_SUB:  alu_s_d = 3'b010;
                        OP_INC:  alu_s_d = 3'b000;
                        default: alu_s_d = 3'b011;
                    endcase
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                res_g_d  = ALU_G;
                // The ALU reports a borrow on its DecA path, so invert it to
                // keep the chained carry as "no borrow" (CIN=1 selects TranA2).
                carry_d  = (op_q == OP_DEC) ? ~ALU_C : ALU_C;
                z_acc_d  = z_acc_q & ALU_Z;
                v_last_d = ALU_V;
                n_last_d = ALU_N;
                state_d  = ST_EMIT;
            end

            ST_EMIT: begin
                if (RES_READY) begin
                    if (last_word) begin
                        flag_v_d = v_last_q;
                        flag_n_d = n_last_q;
                        flag_z_d = z_acc_q;
                        flag_c_d = carry_q;
                        done_d   = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        idx_d   = idx_q + CW'(1);
                        state_d = ST_LOAD;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_ADD;
            cnt_q     <= '0;
            idx_q     <= '0;
            carry_q   <= 1'b0;
            z_acc_q   <= 1'b1;
            v_last_q  <= 1'b0;
            n_last_q  <= 1'b0;
            alu_s_q   <= 3'b000;
            alu_cin_q <= 1'b0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            res_g_q   <= '0;
            flag_v_q  <= 1'b0;
            flag_c_q  <= 1'b0;
            flag_n_q  <= 1'b0;
            flag_z_q  <= 1'b0;
            done_q    <= 1'b0;
`ifdef ALU_SEQ_LEN_CHECK_EN
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            carry_q   <= carry_d;
            z_acc_q   <= z_acc_d;
            v_last_q  <= v_last_d;
            n_last_q  <= n_last_d;
            alu_s_q   <= alu_s_d;
            alu_cin_q <= alu_cin_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            res_g_q   <= res_g_d;
            flag_v_q  <= flag_v_d;
            flag_c_q  <= flag_c_d;
            flag_n_q  <= flag_n_d;
            flag_z_q  <= flag_z_d;
            done_q    <= done_d;
`ifdef ALU_SEQ_LEN_CHECK_EN
            err_q     <= err_d;
`endif
        end
    end

    assign CMD_READY = (state_q == ST_IDLE);
    assign OPD_READY = (state_q == ST_LOAD);
    assign RES_VALID = (state_q == ST_EMIT);
    assign RES_LAST  = (state_q == ST_EMIT) && last_word;
    assign RES_G     = res_g_q;
    assign ALU_S     = alu_s_q;
    assign ALU_CIN   = alu_cin_q;
    assign ALU_A     = alu_a_q;
    assign ALU_B     = alu_b_q;
    assign FLAG_V    = flag_v_q;
    assign FLAG_C    = flag_c_q;
    assign FLAG_N    = flag_n_q;
    assign FLAG_Z    = flag_z_q;
    assign DONE      = done_q;
`ifdef ALU_SEQ_LEN_CHECK_EN
    assign ERR       = err_q;
`else
    assign ERR       = 1'b0;
`endif

endmodule
